// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: operation and
// funct encodings, default latencies, FSM states and the result bundle.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Pending HI/LO result; wr is cleared for a divide by zero.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_res_t;

    // True for any SPECIAL-opcode instruction that touches HI/LO.
    function automatic logic is_md_instr(input logic [31:0] instr);
        logic [5:0] fn;
        fn = instr[5:0];
        return (instr[31:26] == 6'd0) &&
               (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO ||
                fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Pipeline-facing signals of the multiply/divide scheduler.
interface md_sched_if;
    logic [31:0] id_instr;
    logic [2:0]  ex_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_id;

    modport master (
        output id_instr, ex_op, ex_a, ex_b,
        input  hi, lo, busy, stall_id
    );

    modport slave (
        input  id_instr, ex_op, ex_a, ex_b,
        output hi, lo, busy, stall_id
    );
endinterface

// File: rtl/md_alu.sv
// Combinational HI/LO arithmetic: 64-bit products and quotient/remainder.
module md_alu
    import md_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_res_t     res_o
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic        [31:0] uquot;
    logic        [31:0] urem;
    logic               b_zero;
    logic               s_ovf;

    assign sa64   = {{32{a_i[31]}}, a_i};
    assign sb64   = {{32{b_i[31]}}, b_i};
    assign sprod  = sa64 * sb64;
    assign uprod  = {32'd0, a_i} * {32'd0, b_i};
    assign sa     = a_i;
    assign sb     = b_i;
    assign b_zero = (b_i == 32'd0);
    // The one signed quotient that does not fit; kept out of the divider.
    assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign squot  = (b_zero || s_ovf) ? 32'sd0 : (sa / sb);
    assign srem   = (b_zero || s_ovf) ? 32'sd0 : (sa % sb);
    assign uquot  = b_zero ? 32'd0 : (a_i / b_i);
    assign urem   = b_zero ? 32'd0 : (a_i % b_i);

    // Select the result bundle for the issued operation.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_MULT:  res_o = '{hi: sprod[63:32], lo: sprod[31:0], wr: 1'b1};
            OP_MULTU: res_o = '{hi: uprod[63:32], lo: uprod[31:0], wr: 1'b1};
            OP_DIV: begin
                if (s_ovf)
                    res_o = '{hi: 32'd0, lo: 32'h8000_0000, wr: 1'b1};
                else if (!b_zero)
                    res_o = '{hi: srem, lo: squot, wr: 1'b1};
            end
            OP_DIVU: begin
                if (!b_zero)
                    res_o = '{hi: urem, lo: uquot, wr: 1'b1};
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO scheduler: fixed-latency multiply/divide with ID-stage interlock.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    md_sched_if.slave  bus
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    md_res_t            res_q, res_d;
    md_res_t            alu_res;
    md_op_e             op;
    logic               ex_md;

    assign op    = md_op_e'(bus.ex_op);
    assign ex_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

    md_alu u_alu (
        .op_i  (op),
        .a_i   (bus.ex_a),
        .b_i   (bus.ex_b),
        .res_o (alu_res)
    );

    // Next-state: accept work only in IDLE, count down and commit in BUSY.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        res_d   = alu_res;
                        count_d = CNT_W'(MULT_CYC);
                        state_d = ST_BUSY;
                    end
                    OP_DIV, OP_DIVU: begin
                        res_d   = alu_res;
                        count_d = CNT_W'(DIV_CYC);
                        state_d = ST_BUSY;
                    end
                    OP_MTHI: hi_d = bus.ex_a;
                    OP_MTLO: lo_d = bus.ex_a;
                    default: ;
                endcase
            end
            ST_BUSY: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (res_q.wr) begin
                        hi_d = res_q.hi;
                        lo_d = res_q.lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers; reset also drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q == ST_BUSY);
    assign bus.stall_id = is_md_instr(bus.id_instr) & (bus.busy | ex_md);

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched.
module tb_md_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    md_sched_if bus();

    md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ex_op = op;
        bus.ex_a  = a;
        bus.ex_b  = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.id_instr = 32'd0;
        set_op(3'd0, 32'd0, 32'd0);
        step();
        step();
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_id); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        set_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy c%0d got %b exp 1", c, bus.busy); end
            if (c == 1) begin
                checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL mult_old_hi got %h exp 0", bus.hi); end
            end
            step();
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", bus.lo); end
    endtask

    task automatic test_multu();
        set_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        repeat (5) step();
        checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL multu_hi got %h exp 1", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", bus.lo); end
    endtask

    task automatic test_divu_stall();
        bus.id_instr = 32'h0000_0812;
        set_op(3'd4, 32'd7, 32'd2);
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL divu_stall_c0 got %b exp 1", bus.stall_id); end
        step();
        set_op(3'd0, 32'd0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL divu_stall c%0d got %b exp 1", c, bus.stall_id); end
            step();
        end
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL divu_stall_c11 got %b exp 0", bus.stall_id); end
        checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", bus.lo); end
        checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", bus.hi); end
        bus.id_instr = 32'd0;
    endtask

    task automatic test_div_signed();
        set_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        repeat (10) step();
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
    endtask

    task automatic test_div_overflow();
        set_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        repeat (10) step();
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL divovf_hi got %h exp 0", bus.hi); end
    endtask

    task automatic test_div_zero();
        set_op(3'd5, 32'h11, 32'd0);
        step();
        set_op(3'd6, 32'h22, 32'd0);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        checks++; if (bus.hi !== 32'h11) begin errors++; $display("FAIL mthi_setup got %h exp 11", bus.hi); end
        checks++; if (bus.lo !== 32'h22) begin errors++; $display("FAIL mtlo_setup got %h exp 22", bus.lo); end
        set_op(3'd3, 32'd5, 32'd0);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL divz_busy_c1 got %b exp 1", bus.busy); end
        repeat (9) step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL divz_busy_c10 got %b exp 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divz_busy_c11 got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'h11) begin errors++; $display("FAIL divz_hi got %h exp 11", bus.hi); end
        checks++; if (bus.lo !== 32'h22) begin errors++; $display("FAIL divz_lo got %h exp 22", bus.lo); end
    endtask

    task automatic test_mthi_mtlo();
        set_op(3'd5, 32'hDEAD_BEEF, 32'd0);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        checks++; if (bus.hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi got %h exp deadbeef", bus.hi); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
        set_op(3'd1, 32'd3, 32'd4);
        step();
        set_op(3'd6, 32'h55, 32'd0);
        step();
        set_op(3'd3, 32'd100, 32'd7);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        checks++; if (bus.lo !== 32'h22) begin errors++; $display("FAIL mtlo_busy_ignored got %h exp 22", bus.lo); end
        repeat (3) step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_op_ignored got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL mult34_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL mult34_lo got %h exp c", bus.lo); end
    endtask

    task automatic test_nonmd_stall();
        set_op(3'd1, 32'd1, 32'd1);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        bus.id_instr = 32'h0043_0821;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL addu_stall got %b exp 0", bus.stall_id); end
        bus.id_instr = 32'h8C00_0010;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL lw_stall got %b exp 0", bus.stall_id); end
        bus.id_instr = 32'h0000_0810;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL mfhi_stall got %b exp 1", bus.stall_id); end
        bus.id_instr = 32'h0043_0018;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL mult_id_stall got %b exp 1", bus.stall_id); end
        bus.id_instr = 32'd0;
        repeat (5) step();
        checks++; if (bus.lo !== 32'd1) begin errors++; $display("FAIL mult11_lo got %h exp 1", bus.lo); end
    endtask

    task automatic test_reset_mid();
        set_op(3'd5, 32'hAAAA, 32'd0);
        step();
        set_op(3'd1, 32'h1_0000, 32'h1_0000);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
        step();
        rst_n = 1'b1;
        set_op(3'd6, 32'h77, 32'd0);
        step();
        set_op(3'd0, 32'd0, 32'd0);
        checks++; if (bus.lo !== 32'h77) begin errors++; $display("FAIL post_rst_mtlo got %h exp 77", bus.lo); end
        repeat (8) step();
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL no_late_commit_hi got %h exp 0", bus.hi); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_late_busy got %b exp 0", bus.busy); end
        checks++; if (bus.lo !== 32'h77) begin errors++; $display("FAIL no_late_commit_lo got %h exp 77", bus.lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_divu_stall();
        test_div_signed();
        test_div_overflow();
        test_div_zero();
        test_mthi_mtlo();
        test_nonmd_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_instr  input  32  instruction currently in the ID stage.
REQ-006 SHALL have port ex_op  input  3  MD operation issued in EX: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
REQ-007 SHALL have port ex_a  input  32  rs operand of the EX instruction.
REQ-008 SHALL have port ex_b  input  32  rt operand of the EX instruction.
REQ-009 SHALL have port hi  output  32  architectural HI register.
REQ-010 SHALL have port lo  output  32  architectural LO register.
REQ-011 SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-012 SHALL have port stall_id  output  1  freeze PC and IF/ID and insert an ID/EX bubble.

Function
REQ-013 SHALL decode id_is_md = (id_instr[31:26]==0) and funct in {0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}.
REQ-014 SHALL drive stall_id = id_is_md & (busy | ex_op in 1..4), combinationally.
REQ-015 SHALL implement two states, IDLE (count==0) and BUSY (count!=0); busy = (state==BUSY).
REQ-016 In IDLE with ex_op 1/2 at cycle t, SHALL latch result and load count=MULT_CYC; busy is high in cycles t+1..t+MULT_CYC.
REQ-017 In IDLE with ex_op 3/4 at cycle t, SHALL do the same with DIV_CYC.
REQ-018 SHALL decrement count each cycle in BUSY; on the edge where count goes 1->0, SHALL write the latched result to hi/lo and return to IDLE; the new value is visible from cycle t+N+1.
REQ-019 MULT SHALL compute a signed 64-bit product; MULTU SHALL compute an unsigned 64-bit product; HI = bits[63:32], LO = bits[31:0].
REQ-020 DIV SHALL compute a signed quotient into LO and a remainder into HI, truncating toward zero, with the remainder sign following the dividend; DIVU SHALL do the same unsigned.
REQ-021 For a divide with ex_b==0, SHALL run the full DIV_CYC and then leave hi/lo unchanged.
REQ-022 For a divide of 0x80000000 by 0xFFFFFFFF (signed), SHALL produce LO=0x80000000 and HI=0.
REQ-023 In IDLE, ex_op 5 SHALL write ex_a to hi at the next edge, and ex_op 6 SHALL write ex_a to lo at the next edge; neither sets busy.
REQ-024 Any ex_op 1..6 arriving while BUSY SHALL be ignored, leaving state, count and the pending result unchanged.
REQ-025 SHALL NOT gate hi/lo outputs while BUSY; they show the old values until commit.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately set hi=0, lo=0, count=0, state IDLE and busy=0, clearing any pending result, including mid-operation.
REQ-027 On the first edge after rst_n deasserts, SHALL accept a new ex_op normally.

Structure
REQ-028 The ex_op encodings, funct codes and default cycle counts SHALL reside in a shared package md_pkg.
REQ-029 The arithmetic (64-bit product and quotient/remainder selection) SHALL be one sub-module, md_alu, that is purely combinational; md_sched holds all state.

Verification
REQ-030 MULT ex_a=0xFFFFFFFE (-2), ex_b=3 at cycle 0 -> busy in cycles 1..5, HI=0xFFFFFFFF and LO=0xFFFFFFFA from cycle 6.
REQ-031 DIVU ex_a=7, ex_b=2 at cycle 0, with MFLO in ID during cycles 1..10 -> stall_id=1 through cycle 10, 0 in cycle 11; LO=3 and HI=1.
REQ-032 DIV ex_a=-7, ex_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV by 0 with HI=0x11, LO=0x22 before -> after 10 cycles HI=0x11, LO=0x22.
REQ-033 MTHI ex_a=0xDEADBEEF when IDLE -> hi=0xDEADBEEF next cycle, busy stays 0; MTLO while BUSY -> ignored.
REQ-034 rst_n pulled low at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately; no commit occurs later.
REQ-035 Non-MD instruction (ADDU, funct 0x21) in ID while BUSY -> stall_id=0.
